// File: rtl/shift_operand_stage.sv
// ARM-style operand-2 barrel shifter feeding a one-entry registered output stage.
// The ALU consumes out_a/out_b/out_shift_carry/out_alu_op/out_s when out_valid && out_ready.
module shift_operand_stage #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_rm,
   input  logic [7:0]   in_imm8,
   input  logic [3:0]   in_rot,
   input  logic [1:0]   in_mode,
   input  logic [1:0]   in_type,
   input  logic [7:0]   in_amt,
   input  logic         in_cf,
   input  logic [3:0]   in_alu_op,
   input  logic         in_s,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_a,
   output logic [W-1:0] out_b,
   output logic         out_shift_carry,
   output logic [3:0]   out_alu_op,
   output logic         out_s
);

   typedef enum logic [1:0] {
      MODE_IMM_SHIFT = 2'b00,
      MODE_REG_SHIFT = 2'b01,
      MODE_ROT_IMM   = 2'b10,
      MODE_PASS      = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_e;

   function automatic logic [W-1:0] ror_w(input logic [W-1:0] x, input logic [4:0] s);
      logic [2*W-1:0] dbl;
      dbl = {x, x} >> s;
      return dbl[W-1:0];
   endfunction

   mode_e  mode;
   shift_e stype;

   assign mode  = mode_e'(in_mode);
   assign stype = shift_e'(in_type);

   // ------------------------------------------------------------------
   // Shifter
   // ------------------------------------------------------------------
   logic [7:0]   amt_eff;
   logic [W:0]   lsl_ext;
   logic [W:0]   lsr_ext;
   logic [W:0]   asr_ext;
   logic [W-1:0] ror_res;
   logic [W-1:0] imm_rot;
   logic [W-1:0] sh_b;
   logic         sh_c;

   // Immediate LSR/ASR encode a shift of 32 as zero; fold that into one amount.
   always_comb begin
      amt_eff = in_amt;
      if (mode == MODE_IMM_SHIFT) begin
         amt_eff = {3'b000, in_amt[4:0]};
         if ((in_amt[4:0] == 5'd0) && ((stype == SH_LSR) || (stype == SH_ASR))) begin
            amt_eff = 8'd32;
         end
      end
   end

   // One extra bit on the shifted-out side captures the carry for any amount,
   // including 32 and beyond, without special-casing the index.
   assign lsl_ext = {1'b0, in_rm} << amt_eff;
   assign lsr_ext = {in_rm, 1'b0} >> amt_eff;
   assign asr_ext = $signed({in_rm, 1'b0}) >>> amt_eff;
   assign ror_res = ror_w(in_rm, amt_eff[4:0]);
   assign imm_rot = ror_w({{(W-8){1'b0}}, in_imm8}, {in_rot, 1'b0});

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      sh_b = in_rm;
      sh_c = in_cf;
      unique case (mode)
         MODE_IMM_SHIFT, MODE_REG_SHIFT: begin
            if (amt_eff == 8'd0) begin
               if ((mode == MODE_IMM_SHIFT) && (stype == SH_ROR)) begin
                  sh_b = {in_cf, in_rm[W-1:1]};
                  sh_c = in_rm[0];
               end
            end else begin
               unique case (stype)
                  SH_LSL: begin
                     sh_b = lsl_ext[W-1:0];
                     sh_c = lsl_ext[W];
                  end
                  SH_LSR: begin
                     sh_b = lsr_ext[W:1];
                     sh_c = lsr_ext[0];
                  end
                  SH_ASR: begin
                     sh_b = asr_ext[W:1];
                     sh_c = asr_ext[0];
                  end
                  SH_ROR: begin
                     // Bit 31 of the rotated word is the last bit rotated out,
                     // which also covers the multiple-of-32 register case.
                     sh_b = ror_res;
                     sh_c = ror_res[W-1];
                  end
                  default: ;
               endcase
            end
         end
         MODE_ROT_IMM: begin
            sh_b = imm_rot;
            sh_c = (in_rot == 4'd0) ? in_cf : imm_rot[W-1];
         end
         MODE_PASS: ;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // One-entry output register
   // ------------------------------------------------------------------
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_a_q, out_a_d;
   logic [W-1:0] out_b_q, out_b_d;
   logic         out_carry_q, out_carry_d;
   logic [3:0]   out_alu_op_q, out_alu_op_d;
   logic         out_s_q, out_s_d;
   logic         accept;
   logic         load;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign load     = accept && !flush;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_a_d      = out_a_q;
      out_b_d      = out_b_q;
      out_carry_d  = out_carry_q;
      out_alu_op_d = out_alu_op_q;
      out_s_d      = out_s_q;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (load) begin
         out_a_d      = in_a;
         out_b_d      = sh_b;
         out_carry_d  = sh_c;
         out_alu_op_d = in_alu_op;
         out_s_d      = in_s;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_a_q      <= '0;
         out_b_q      <= '0;
         out_carry_q  <= 1'b0;
         out_alu_op_q <= '0;
         out_s_q      <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_a_q      <= out_a_d;
         out_b_q      <= out_b_d;
         out_carry_q  <= out_carry_d;
         out_alu_op_q <= out_alu_op_d;
         out_s_q      <= out_s_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_a           = out_a_q;
   assign out_b           = out_b_q;
   assign out_shift_carry = out_carry_q;
   assign out_alu_op      = out_alu_op_q;
   assign out_s           = out_s_q;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Self-checking bench for shift_operand_stage: directed boundary vectors, handshake
// scenarios and randomized traffic against an iterative one-bit-per-step shifter model.
module tb_shift_operand_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_rm;
   logic [7:0]  in_imm8;
   logic [3:0]  in_rot;
   logic [1:0]  in_mode;
   logic [1:0]  in_type;
   logic [7:0]  in_amt;
   logic        in_cf;
   logic [3:0]  in_alu_op;
   logic        in_s;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic        out_shift_carry;
   logic [3:0]  out_alu_op;
   logic        out_s;

   int n_checks = 0;
   int n_fail   = 0;

   shift_operand_stage #(.W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_rm(in_rm), .in_imm8(in_imm8), .in_rot(in_rot),
      .in_mode(in_mode), .in_type(in_type), .in_amt(in_amt), .in_cf(in_cf),
      .in_alu_op(in_alu_op), .in_s(in_s),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_shift_carry(out_shift_carry),
      .out_alu_op(out_alu_op), .out_s(out_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  mode;
      logic [1:0]  typ;
      logic [7:0]  amt;
      logic [31:0] rm;
      logic [7:0]  imm8;
      logic [3:0]  rot;
      logic        cf;
      logic [31:0] exp_b;
      logic        exp_c;
   } vec_t;

   // Reference shifter: applies shifts one bit at a time, the way the
   // architecture describes them, and returns {carry, result}.
   function automatic logic [32:0] ref_shift(input logic [1:0] mode, input logic [1:0] typ,
                                             input logic [7:0] amt, input logic [31:0] x,
                                             input logic [7:0] imm8, input logic [3:0] rot,
                                             input logic cf);
      logic [31:0] r;
      logic        c;
      int          n;
      r = x;
      c = cf;
      n = 0;
      if (mode == 2'b10) begin
         r = {24'h0, imm8};
         for (int i = 0; i < 2 * int'(rot); i++) r = {r[0], r[31:1]};
         c = (rot == 4'd0) ? cf : r[31];
      end else if (mode == 2'b00 || mode == 2'b01) begin
         if (mode == 2'b00) begin
            n = int'(amt[4:0]);
            if (n == 0 && (typ == 2'b01 || typ == 2'b10)) n = 32;
            if (n == 0 && typ == 2'b11) begin
               r = {cf, x[31:1]};
               c = x[0];
            end
         end else begin
            n = int'(amt);
         end
         for (int i = 0; i < n; i++) begin
            case (typ)
               2'b00: begin c = r[31]; r = r << 1; end
               2'b01: begin c = r[0];  r = r >> 1; end
               2'b10: begin c = r[0];  r = {r[31], r[31:1]}; end
               default: begin c = r[0]; r = {r[0], r[31:1]}; end
            endcase
         end
      end
      return {c, r};
   endfunction

   task automatic set_op(input logic [1:0] mode, input logic [1:0] typ, input logic [7:0] amt,
                         input logic [31:0] rm, input logic [7:0] imm8, input logic [3:0] rot,
                         input logic cf);
      in_mode = mode;
      in_type = typ;
      in_amt  = amt;
      in_rm   = rm;
      in_imm8 = imm8;
      in_rot  = rot;
      in_cf   = cf;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
      in_a = 32'h0000_0011; in_alu_op = 4'h3; in_s = 1'b1;
      set_op(2'b11, 2'b01, 8'd5, 32'hCAFE_F00D, 8'h00, 4'h0, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s} !== 70'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%0b a=%h b=%h c=%0b op=%h s=%0b, want all zero",
                  out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %0b want 1", in_ready);
      end
      rst_n = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s} !==
          {1'b1, 32'h0000_0011, 32'hCAFE_F00D, 1'b1, 4'h3, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_first_accept: got valid=%0b a=%h b=%h c=%0b op=%h s=%0b, want 1 00000011 cafef00d 1 3 1",
                  out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_imm_shift();
      vec_t v[$];
      logic [32:0] m;
      v.push_back('{2'b00, 2'b00, 8'd4,  32'hF000_000F, 8'h00, 4'h0, 1'b0, 32'h0000_00F0, 1'b1});
      v.push_back('{2'b00, 2'b01, 8'd0,  32'h8000_0001, 8'h00, 4'h0, 1'b0, 32'h0000_0000, 1'b1});
      v.push_back('{2'b00, 2'b11, 8'd0,  32'h0000_0003, 8'h00, 4'h0, 1'b1, 32'h8000_0001, 1'b1});
      v.push_back('{2'b00, 2'b10, 8'd0,  32'h8000_0000, 8'h00, 4'h0, 1'b0, 32'hFFFF_FFFF, 1'b1});
      v.push_back('{2'b00, 2'b00, 8'd0,  32'h0000_0005, 8'h00, 4'h0, 1'b0, 32'h0000_0005, 1'b0});
      v.push_back('{2'b00, 2'b01, 8'd31, 32'hC000_0000, 8'h00, 4'h0, 1'b0, 32'h0000_0001, 1'b1});
      v.push_back('{2'b11, 2'b01, 8'd7,  32'h1234_5678, 8'h00, 4'h0, 1'b1, 32'h1234_5678, 1'b1});
      out_ready = 1'b1;
      foreach (v[i]) begin
         set_op(v[i].mode, v[i].typ, v[i].amt, v[i].rm, v[i].imm8, v[i].rot, v[i].cf);
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         m = ref_shift(v[i].mode, v[i].typ, v[i].amt, v[i].rm, v[i].imm8, v[i].rot, v[i].cf);
         n_checks++;
         if ({out_valid, out_b, out_shift_carry} !== {1'b1, v[i].exp_b, v[i].exp_c}) begin
            n_fail++;
            $display("FAIL imm_shift[%0d]: got valid=%0b b=%h c=%0b, want 1 %h %0b",
                     i, out_valid, out_b, out_shift_carry, v[i].exp_b, v[i].exp_c);
         end
         n_checks++;
         if ({out_shift_carry, out_b} !== m) begin
            n_fail++;
            $display("FAIL imm_shift_model[%0d]: got %h want %h", i, {out_shift_carry, out_b}, m);
         end
      end
   endtask

   task automatic test_reg_shift();
      vec_t v[$];
      v.push_back('{2'b01, 2'b00, 8'd0,   32'h8000_0001, 8'h00, 4'h0, 1'b1, 32'h8000_0001, 1'b1});
      v.push_back('{2'b01, 2'b00, 8'd32,  32'h8000_0001, 8'h00, 4'h0, 1'b0, 32'h0000_0000, 1'b1});
      v.push_back('{2'b01, 2'b00, 8'd40,  32'h8000_0001, 8'h00, 4'h0, 1'b1, 32'h0000_0000, 1'b0});
      v.push_back('{2'b01, 2'b10, 8'd200, 32'h8000_0001, 8'h00, 4'h0, 1'b0, 32'hFFFF_FFFF, 1'b1});
      v.push_back('{2'b01, 2'b11, 8'd64,  32'h8000_0001, 8'h00, 4'h0, 1'b0, 32'h8000_0001, 1'b1});
      v.push_back('{2'b01, 2'b01, 8'd32,  32'h8000_0001, 8'h00, 4'h0, 1'b0, 32'h0000_0000, 1'b1});
      v.push_back('{2'b01, 2'b01, 8'd33,  32'h8000_0001, 8'h00, 4'h0, 1'b1, 32'h0000_0000, 1'b0});
      v.push_back('{2'b01, 2'b11, 8'd36,  32'h0000_00F8, 8'h00, 4'h0, 1'b0, 32'h8000_000F, 1'b1});
      out_ready = 1'b1;
      foreach (v[i]) begin
         set_op(v[i].mode, v[i].typ, v[i].amt, v[i].rm, v[i].imm8, v[i].rot, v[i].cf);
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         n_checks++;
         if ({out_valid, out_b, out_shift_carry} !== {1'b1, v[i].exp_b, v[i].exp_c}) begin
            n_fail++;
            $display("FAIL reg_shift[%0d]: got valid=%0b b=%h c=%0b, want 1 %h %0b",
                     i, out_valid, out_b, out_shift_carry, v[i].exp_b, v[i].exp_c);
         end
      end
   endtask

   task automatic test_rot_imm();
      vec_t v[$];
      v.push_back('{2'b10, 2'b00, 8'd0, 32'h1111_1111, 8'hFF, 4'h4, 1'b0, 32'hFF00_0000, 1'b1});
      v.push_back('{2'b10, 2'b01, 8'd0, 32'h2222_2222, 8'h01, 4'h0, 1'b0, 32'h0000_0001, 1'b0});
      v.push_back('{2'b10, 2'b11, 8'd9, 32'h3333_3333, 8'h81, 4'h0, 1'b1, 32'h0000_0081, 1'b1});
      v.push_back('{2'b10, 2'b10, 8'd3, 32'h4444_4444, 8'h02, 4'h1, 1'b1, 32'h8000_0000, 1'b1});
      v.push_back('{2'b10, 2'b00, 8'd0, 32'h5555_5555, 8'h3C, 4'hF, 1'b1, 32'h0000_00F0, 1'b0});
      out_ready = 1'b1;
      foreach (v[i]) begin
         set_op(v[i].mode, v[i].typ, v[i].amt, v[i].rm, v[i].imm8, v[i].rot, v[i].cf);
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         n_checks++;
         if ({out_valid, out_b, out_shift_carry} !== {1'b1, v[i].exp_b, v[i].exp_c}) begin
            n_fail++;
            $display("FAIL rot_imm[%0d]: got valid=%0b b=%h c=%0b, want 1 %h %0b",
                     i, out_valid, out_b, out_shift_carry, v[i].exp_b, v[i].exp_c);
         end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1; flush = 1'b0;
      in_a = 32'hAAAA_0001; in_alu_op = 4'h1; in_s = 1'b0;
      set_op(2'b00, 2'b00, 8'd4, 32'hF000_000F, 8'h00, 4'h0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_a = 32'hBBBB_0002; in_alu_op = 4'h2; in_s = 1'b1;
      set_op(2'b10, 2'b00, 8'd0, 32'h0, 8'hFF, 4'h4, 1'b0);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready[%0d]: got %0b want 0", k, in_ready);
         end
         @(posedge clk); #1;
         n_checks++;
         if ({out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s} !==
             {1'b1, 32'hAAAA_0001, 32'h0000_00F0, 1'b1, 4'h1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got valid=%0b a=%h b=%h c=%0b op=%h s=%0b, want op1",
                     k, out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s);
         end
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready: got %0b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s} !==
          {1'b1, 32'hBBBB_0002, 32'hFF00_0000, 1'b1, 4'h2, 1'b1}) begin
         n_fail++;
         $display("FAIL bp_op2: got valid=%0b a=%h b=%h c=%0b op=%h s=%0b, want op2",
                  out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out_b} !== {1'b0, 32'hFF00_0000}) begin
         n_fail++;
         $display("FAIL bp_drain: got valid=%0b b=%h, want 0 ff000000", out_valid, out_b);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      in_a = 32'h0; in_alu_op = 4'h0; in_s = 1'b0;
      set_op(2'b11, 2'b00, 8'd0, 32'h0BAD_F00D, 8'h00, 4'h0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      set_op(2'b11, 2'b00, 8'd0, 32'hDEAD_DEAD, 8'h00, 4'h0, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_checks++;
      if ({out_valid, out_b, out_shift_carry} !== {1'b0, 32'h0BAD_F00D, 1'b0}) begin
         n_fail++;
         $display("FAIL flush_discard: got valid=%0b b=%h c=%0b, want 0 0badf00d 0",
                  out_valid, out_b, out_shift_carry);
      end
      in_a = 32'h1357_9BDF; in_alu_op = 4'hA; in_s = 1'b1;
      set_op(2'b01, 2'b01, 8'd4, 32'h0000_0018, 8'h00, 4'h0, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s} !==
          {1'b1, 32'h1357_9BDF, 32'h0000_0001, 1'b1, 4'hA, 1'b1}) begin
         n_fail++;
         $display("FAIL flush_resume: got valid=%0b a=%h b=%h c=%0b op=%h s=%0b, want 1 13579bdf 00000001 1 a 1",
                  out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s);
      end
      out_ready = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_stalled: got valid=%0b want 0", out_valid);
      end
   endtask

   task automatic test_cf_hold();
      out_ready = 1'b1;
      set_op(2'b00, 2'b00, 8'd0, 32'h0000_0042, 8'h00, 4'h0, 1'b1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0; in_cf = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out_b, out_shift_carry} !== {1'b1, 32'h0000_0042, 1'b1}) begin
         n_fail++;
         $display("FAIL cf_hold: got valid=%0b b=%h c=%0b, want 1 00000042 1",
                  out_valid, out_b, out_shift_carry);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [32:0] m;
      logic [32:0] exp_bc;
      logic [31:0] exp_a;
      logic [3:0]  exp_op;
      logic        exp_s;
      logic        exp_v;
      logic [7:0]  amt;
      exp_bc = {out_shift_carry, out_b};
      exp_a  = out_a; exp_op = out_alu_op; exp_s = out_s;
      out_ready = 1'b1; flush = 1'b0;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0: amt = 8'd0;
            1: amt = 8'd1;
            2: amt = 8'd31;
            3: amt = 8'd32;
            4: amt = 8'd33;
            default: amt = 8'($urandom);
         endcase
         set_op(2'($urandom), 2'($urandom), amt, $urandom, 8'($urandom), 4'($urandom), 1'($urandom));
         in_a = $urandom; in_alu_op = 4'($urandom); in_s = 1'($urandom);
         in_valid = ($urandom_range(0, 4) != 0);
         exp_v = in_valid;
         if (in_valid) begin
            m = ref_shift(in_mode, in_type, in_amt, in_rm, in_imm8, in_rot, in_cf);
            exp_bc = m; exp_a = in_a; exp_op = in_alu_op; exp_s = in_s;
         end
         @(posedge clk); #1;
         n_checks++;
         if ({out_valid, out_shift_carry, out_b, out_a, out_alu_op, out_s} !==
             {exp_v, exp_bc, exp_a, exp_op, exp_s}) begin
            n_fail++;
            $display("FAIL random[%0d]: got valid=%0b c=%0b b=%h a=%h op=%h s=%0b, want %0b %0b %h %h %h %0b",
                     i, out_valid, out_shift_carry, out_b, out_a, out_alu_op, out_s,
                     exp_v, exp_bc[32], exp_bc[31:0], exp_a, exp_op, exp_s);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      in_a = 32'hFFFF_FFFF; in_alu_op = 4'hF; in_s = 1'b1;
      set_op(2'b11, 2'b00, 8'd0, 32'h7777_7777, 8'h00, 4'h0, 1'b1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s} !== 70'd0) begin
         n_fail++;
         $display("FAIL reset_midflight: got valid=%0b a=%h b=%h c=%0b op=%h s=%0b, want all zero",
                  out_valid, out_a, out_b, out_shift_carry, out_alu_op, out_s);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_midflight_ready: got %0b want 1", in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_imm_shift();
      test_reg_shift();
      test_rot_imm();
      test_backpressure();
      test_flush();
      test_cf_hold();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- Registered operand-preparation stage directly upstream of the main ALU.
- Takes the raw second operand (register value or 8-bit immediate) and applies the ARM-style barrel shift or rotate.
- Latches the shifted operand, its shifter carry-out, the first operand, ALU opcode and S bit into a one-entry output register.
- The ALU consumes this register: out_b feeds B, out_shift_carry feeds Shift_carry_out, out_a feeds A, out_alu_op feeds ALU_op, out_s feeds S.

Parameters:
- W, 32, datapath width; only 32 is supported, and shift/rotate semantics assume 32.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the held entry.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  stage can accept this cycle.
- in_a  in  32  first operand (Rn), passed through.
- in_rm  in  32  register operand to shift.
- in_imm8  in  8  immediate byte for rotate-immediate mode.
- in_rot  in  4  rotate field; rotation = 2*in_rot.
- in_mode  in  2  00 imm-shift, 01 reg-shift, 10 rot-imm, 11 pass (in_rm, carry=in_cf).
- in_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_amt  in  8  shift amount; imm-shift uses [4:0], reg-shift uses all 8 bits (Rs[7:0]).
- in_cf  in  1  current C flag, from ALU NZCV[1].
- in_alu_op  in  4  passed through.
- in_s  in  1  passed through.
- out_valid  out  1  held entry valid.
- out_ready  in  1  ALU side consumes the entry this cycle.
- out_a  out  32  registered first operand.
- out_b  out  32  registered shifted operand.
- out_shift_carry  out  1  registered shifter carry-out.
- out_alu_op  out  4  registered opcode.
- out_s  out  1  registered S bit.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0; out_a=0, out_b=0, out_shift_carry=0, out_alu_op=0, out_s=0.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept = in_valid && in_ready. On accept at posedge: all out_* load the shifter result and pass-through fields, and out_valid becomes 1.
  - Latency: 1 cycle.
  - Back-to-back accepts every cycle are allowed while out_ready=1.
- If out_valid && out_ready && !in_valid at posedge: out_valid becomes 0 and the data fields hold their last value.
- If out_valid && !out_ready: all out_* hold stable and in_ready=0.
- flush=1 at posedge: out_valid becomes 0 and any simultaneous accept is discarded. Flush has priority over accept.
- in_cf is sampled at the accept edge only. A flag change after accept does not alter the held out_shift_carry.
- Shifter is combinational on the in_* fields. Let x=in_rm and n=amount.
- imm-shift, n=in_amt[4:0]:
  - LSL n=0: x, c=in_cf.
  - LSL 1..31: x<<n, c=x[32-n].
  - LSR n=0 means shift 32: result 0, c=x[31].
  - LSR 1..31: c=x[n-1].
  - ASR n=0 means 32: result all x[31], c=x[31].
  - ASR 1..31: c=x[n-1].
  - ROR n=0 is RRX: {in_cf,x[31:1]}, c=x[0].
  - ROR 1..31: rotate right, c=x[n-1].
- reg-shift, n=in_amt[7:0]:
  - n=0 for any type: x, c=in_cf.
  - LSL: n<32 as above; n=32 gives 0, c=x[0]; n>32 gives 0, c=0.
  - LSR: n<32 as above; n=32 gives 0, c=x[31]; n>32 gives 0, c=0.
  - ASR: n>=32 gives all x[31], c=x[31].
  - ROR: n[4:0]=0 with n!=0 gives x, c=x[31]; otherwise rotate by n[4:0], c=x[n[4:0]-1].
- rot-imm: v = zero-extended in_imm8 rotated right by 2*in_rot.
  - c=in_cf if in_rot=0, else v[31].
- pass mode: out_b=in_rm, c=in_cf.
- in_type is ignored in rot-imm and pass modes.
- Reset asserted mid-transfer drops the entry immediately. No partial state survives.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, all out_*=0, in_ready=1. Release rst_n -> accept on the next edge.
- imm-shift LSL #4 on in_rm=0xF000_000F -> one cycle after accept, out_b=0x0000_00F0, carry=1. LSR #0 on 0x8000_0001 -> out_b=0, carry=1. ROR #0 (RRX) with in_cf=1 on 0x0000_0003 -> out_b=0x8000_0001, carry=1.
- reg-shift on 0x8000_0001:
  - amt=0, in_cf=1 -> out_b unchanged, carry=1.
  - LSL 32 -> out_b=0, carry=1.
  - LSL 40 -> out_b=0, carry=0.
  - ASR 200 -> out_b=0xFFFF_FFFF, carry=1.
  - ROR 64 -> out_b=0x8000_0001, carry=1.
- rot-imm: imm8=0xFF, rot=4 -> out_b=0xFF00_0000, carry=1. imm8=0x01, rot=0, in_cf=0 -> out_b=1, carry=0.
- Backpressure: accept op1, hold out_ready=0 for 3 cycles while in_valid=1 with op2 -> in_ready=0 and out_* remain op1. Raise out_ready -> op2 is accepted at the same edge and appears the next cycle with no bubble and no loss.
- Flush: flush=1 together with an accept -> out_valid=0 next cycle. Following accept with flush=0 -> normal result, and pass-through of in_a, in_alu_op=4'hA, in_s=1 is verified.
